// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake and operand/result bundle for seq_restoring_divider.
// div_by_zero is present only when DIVIDER_ERR_EN is defined.
interface seq_restoring_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             busy;
  logic             done;
`ifdef DIVIDER_ERR_EN
  logic             div_by_zero;
`endif

  modport master (
    output start,
    output Dividend,
    output Divisor,
    input  Quotient,
    input  Remainder,
    input  busy,
`ifdef DIVIDER_ERR_EN
    input  div_by_zero,
`endif
    input  done
  );

  modport slave (
    input  start,
    input  Dividend,
    input  Divisor,
    output Quotient,
    output Remainder,
    output busy,
`ifdef DIVIDER_ERR_EN
    output div_by_zero,
`endif
    output done
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock, WIDTH+1 cycles start-to-done.
// DIVIDER_ERR_EN adds div_by_zero and a single-cycle early exit for a zero divisor.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_restoring_divider_if.slave dif
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef DIVIDER_ERR_EN
  logic             dbz_q, dbz_d;
`endif

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] r_step;

  always_comb begin
    // Trial subtraction as an add of the inverted divisor with carry-in 1.
    trial = {r_q, q_q[WIDTH-1]} + {1'b1, ~d_q} + {{WIDTH{1'b0}}, 1'b1};
    if (!trial[WIDTH]) begin
      r_step = trial[WIDTH-1:0];
      q_step = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      r_step = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
      q_step = {q_q[WIDTH-2:0], 1'b0};
    end

    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef DIVIDER_ERR_EN
    dbz_d   = dbz_q;
`endif

    case (state_q)
      RUN: begin
        q_d   = q_step;
        r_d   = r_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          quot_d  = q_step;
          rem_d   = r_step;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request.
        state_d = IDLE;
        if (dif.start) begin
          q_d     = dif.Dividend;
          d_d     = dif.Divisor;
          r_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef DIVIDER_ERR_EN
          dbz_d   = 1'b0;
          if (dif.Divisor == '0) begin
            quot_d  = '1;
            rem_d   = dif.Dividend;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIVIDER_ERR_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DIVIDER_ERR_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign dif.Quotient  = quot_q;
  assign dif.Remainder = rem_q;
  assign dif.busy      = busy_q;
  assign dif.done      = done_q;
`ifdef DIVIDER_ERR_EN
  assign dif.div_by_zero = dbz_q;
`endif
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider (WIDTH=4): directed scenarios, exhaustive sweep and
// random traffic against a cycle-level arithmetic model; honours DIVIDER_ERR_EN.
module tb_seq_restoring_divider;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  seq_restoring_divider_if #(.WIDTH(W)) dif();
  seq_restoring_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .dif(dif));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, got, want);
    end
  endtask

  // Model: result computed with / and %, timed by an edge countdown.
  logic [W-1:0] m_q, m_r, p_q, p_r;
  logic         m_busy, m_done, m_dbz;
  int           m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_q <= '0; m_r <= '0; p_q <= '0; p_r <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 1) begin
        m_left <= m_left - 1;
      end else if (m_left == 1) begin
        m_left <= 0; m_busy <= 1'b0; m_done <= 1'b1; m_q <= p_q; m_r <= p_r;
      end else if (dif.start) begin
        m_dbz <= 1'b0;
        if (dif.Divisor == '0) begin
          p_q <= '1; p_r <= dif.Dividend;
        end else begin
          p_q <= dif.Dividend / dif.Divisor; p_r <= dif.Dividend % dif.Divisor;
        end
`ifdef DIVIDER_ERR_EN
        if (dif.Divisor == '0) begin
          m_done <= 1'b1; m_q <= '1; m_r <= dif.Dividend; m_dbz <= 1'b1;
        end else begin
          m_left <= W; m_busy <= 1'b1;
        end
`else
        m_left <= W; m_busy <= 1'b1;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_busy", 32'(dif.busy), 32'(m_busy));
      chk("cyc_done", 32'(dif.done), 32'(m_done));
      chk("cyc_quot", 32'(dif.Quotient), 32'(m_q));
      chk("cyc_rem",  32'(dif.Remainder), 32'(m_r));
`ifdef DIVIDER_ERR_EN
      chk("cyc_dbz",  32'(dif.div_by_zero), 32'(m_dbz));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, let the next edge accept it, then scramble the operands.
  task automatic go(input logic [W-1:0] a, input logic [W-1:0] b);
    dif.start = 1'b1; dif.Dividend = a; dif.Divisor = b;
    tick();
    dif.start = 1'b0;
    dif.Dividend = W'($urandom);
    dif.Divisor  = W'($urandom);
  endtask

  task automatic wait_done(input string name, output int e);
    e = 0;
    while (dif.done !== 1'b1 && e < 40) begin
      tick();
      e++;
    end
    chk({name, "_done_seen"}, 32'(dif.done), 32'd1);
  endtask

  task automatic count_dones(input int n, output int dones);
    dones = 0;
    repeat (n) begin
      tick();
      if (dif.done === 1'b1) dones++;
    end
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_busy"}, 32'(dif.busy), 32'd0);
    chk({name, "_done"}, 32'(dif.done), 32'd0);
    chk({name, "_quot"}, 32'(dif.Quotient), 32'd0);
    chk({name, "_rem"},  32'(dif.Remainder), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got timeout want finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    int nd;
    dif.start = 1'b0; dif.Dividend = '0; dif.Divisor = '0;
    #3;
    chk_zero_outputs("reset");
`ifdef DIVIDER_ERR_EN
    chk("reset_dbz", 32'(dif.div_by_zero), 32'd0);
`endif
    tick(); tick();
    rst = 1'b0;
    tick();

    // 13/3: busy on after the accepting edge, done after edge 5.
    go(4'd13, 4'd3);
    chk("s1_busy_after_accept", 32'(dif.busy), 32'd1);
    chk("s1_quot_holds", 32'(dif.Quotient), 32'd0);
    wait_done("s1", e);
    chk("s1_latency", 32'(e), 32'd4);
    chk("s1_quot", 32'(dif.Quotient), 32'd4);
    chk("s1_rem",  32'(dif.Remainder), 32'd1);
    chk("s1_busy_at_done", 32'(dif.busy), 32'd0);
    count_dones(5, nd);
    chk("s1_single_done", 32'(nd), 32'd0);
    chk("s1_quot_stable", 32'(dif.Quotient), 32'd4);
    chk("s1_rem_stable",  32'(dif.Remainder), 32'd1);

    // 7/9, then 15/1 started in the DONE cycle.
    go(4'd7, 4'd9);
    wait_done("s2a", e);
    chk("s2a_quot", 32'(dif.Quotient), 32'd0);
    chk("s2a_rem",  32'(dif.Remainder), 32'd7);
    go(4'd15, 4'd1);
    chk("s2b_busy_no_gap", 32'(dif.busy), 32'd1);
    chk("s2b_quot_holds", 32'(dif.Quotient), 32'd0);
    wait_done("s2b", e);
    chk("s2b_latency", 32'(e), 32'd4);
    chk("s2b_quot", 32'(dif.Quotient), 32'd15);
    chk("s2b_rem",  32'(dif.Remainder), 32'd0);
    tick();

    // A start while busy is ignored.
    go(4'd13, 4'd3);
    tick();
    dif.start = 1'b1; dif.Dividend = 4'd6; dif.Divisor = 4'd2;
    tick();
    dif.start = 1'b0;
    wait_done("s3", e);
    chk("s3_quot", 32'(dif.Quotient), 32'd4);
    chk("s3_rem",  32'(dif.Remainder), 32'd1);
    count_dones(10, nd);
    chk("s3_no_second_done", 32'(nd), 32'd0);

    // Asynchronous reset between edges aborts the division.
    go(4'd13, 4'd3);
    tick();
    #1 rst = 1'b1;
    #1 chk_zero_outputs("s4_async");
    tick();
    rst = 1'b0;
    count_dones(8, nd);
    chk("s4_no_done", 32'(nd), 32'd0);
    go(4'd9, 4'd4);
    wait_done("s4", e);
    chk("s4_quot", 32'(dif.Quotient), 32'd2);
    chk("s4_rem",  32'(dif.Remainder), 32'd1);
    tick();

    // Zero divisor.
    go(4'd10, 4'd0);
`ifdef DIVIDER_ERR_EN
    chk("s5_done_early", 32'(dif.done), 32'd1);
    wait_done("s5", e);
    chk("s5_latency", 32'(e), 32'd0);
    chk("s5_dbz", 32'(dif.div_by_zero), 32'd1);
`else
    wait_done("s5", e);
    chk("s5_latency", 32'(e), 32'd4);
`endif
    chk("s5_quot", 32'(dif.Quotient), 32'd15);
    chk("s5_rem",  32'(dif.Remainder), 32'd10);
    tick(); tick();
    go(4'd5, 4'd2);
`ifdef DIVIDER_ERR_EN
    chk("s5_dbz_cleared", 32'(dif.div_by_zero), 32'd0);
`endif
    wait_done("s5b", e);
    chk("s5b_quot", 32'(dif.Quotient), 32'd2);
    chk("s5b_rem",  32'(dif.Remainder), 32'd1);

    // Exhaustive nonzero-divisor sweep, back to back.
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        go(W'(a), W'(b));
        wait_done("sweep", e);
        chk("sweep_quot", 32'(dif.Quotient), 32'(a / b));
        chk("sweep_rem",  32'(dif.Remainder), 32'(a % b));
      end
    end
    tick();

    // Random traffic, including starts while busy and zero divisors.
    repeat (600) begin
      dif.start    = 1'($urandom_range(0, 1));
      dif.Dividend = W'($urandom);
      dif.Divisor  = W'($urandom_range(0, 15));
      tick();
    end
    dif.start = 1'b0;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
